// File: rtl/gon_y_bus_driver.sv
// GON Y-bus source stage: packet FIFO, registered Y-bus driver with
// enable/ready handshake, row-ID shadow broadcast and stall counter.
module gon_y_bus_driver #(
    parameter int NUM_ROWS   = 12,
    parameter int ROW_LEN    = 4,
    parameter int ID_LEN     = 5,
    parameter int VALUE_LEN  = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_we,
    input  logic [$clog2(NUM_ROWS)-1:0]   cfg_row,
    input  logic [ROW_LEN-1:0]            cfg_id,
    input  logic                          cfg_commit,
    output logic [NUM_ROWS*ROW_LEN-1:0]   id_bus,
    output logic                          set_id,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [ROW_LEN-1:0]            in_row_tag,
    input  logic [ID_LEN-1:0]             in_col_tag,
    input  logic [VALUE_LEN-1:0]          in_value,
    output logic [ROW_LEN-1:0]            bus_tag,
    output logic [ID_LEN-1:0]             bus_tag_id,
    output logic [VALUE_LEN-1:0]          bus_value,
    output logic                          bus_enable,
    input  logic                          bus_ready,
    output logic                          busy,
    input  logic                          stall_clr,
    output logic [15:0]                   stall_cnt
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PKT_W = ROW_LEN + ID_LEN + VALUE_LEN;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t state, state_next;

    logic [PKT_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             empty, full, push, pop;
    logic             commit_pend, commit_pend_next, commit_req, transfer;

    logic [ROW_LEN-1:0]   head_tag;
    logic [ID_LEN-1:0]    head_id;
    logic [VALUE_LEN-1:0] head_value;

    assign empty      = (count == '0);
    assign full       = (count == (AW+1)'(FIFO_DEPTH));
    assign in_ready   = rst & ~full;
    assign push       = in_valid & in_ready;
    assign transfer   = bus_enable & bus_ready;
    assign commit_req = commit_pend | cfg_commit;
    assign busy       = ~empty | bus_enable | commit_pend | (state == COMMIT);

    assign {head_tag, head_id, head_value} = mem[rd_ptr];

    // Packet storage; contents need no reset since the pointers gate them
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {in_row_tag, in_col_tag, in_value};
    end

    // FIFO pointers and occupancy; power-of-2 depth lets pointers wrap naturally
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Next-state logic: a commit request always outranks issuing the next packet
    always_comb begin
        state_next       = state;
        pop              = 1'b0;
        commit_pend_next = commit_pend;
        case (state)
            IDLE: begin
                if (commit_req) begin
                    state_next = COMMIT;
                end else if (!empty) begin
                    state_next = ISSUE;
                    pop        = 1'b1;
                end
            end
            ISSUE: begin
                commit_pend_next = commit_req;
                if (transfer) begin
                    if (commit_req) begin
                        state_next = COMMIT;
                    end else if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            COMMIT: begin
                state_next       = IDLE;
                commit_pend_next = cfg_commit;
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM state, registered bus outputs and the set_id strobe
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            commit_pend <= 1'b0;
            bus_enable  <= 1'b0;
            set_id      <= 1'b0;
            bus_tag     <= '0;
            bus_tag_id  <= '0;
            bus_value   <= '0;
        end else begin
            state       <= state_next;
            commit_pend <= commit_pend_next;
            bus_enable  <= (state_next == ISSUE);
            set_id      <= (state_next == COMMIT);
            if (pop) begin
                bus_tag    <= head_tag;
                bus_tag_id <= head_id;
                bus_value  <= head_value;
            end else if (transfer) begin
                bus_tag    <= '0;
                bus_tag_id <= '0;
                bus_value  <= '0;
            end
        end
    end

    // Row-ID shadow registers; out-of-range rows are dropped
    always_ff @(posedge clk) begin
        if (!rst) begin
            id_bus <= '0;
        end else if (cfg_we && (32'(cfg_row) < NUM_ROWS)) begin
            id_bus[cfg_row*ROW_LEN +: ROW_LEN] <= cfg_id;
        end
    end

    // Saturating stall counter; clear wins over increment
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (stall_clr) begin
            stall_cnt <= '0;
        end else if (bus_enable && !bus_ready && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_gon_y_bus_driver.sv
// Directed self-checking bench for gon_y_bus_driver.
module tb_gon_y_bus_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [3:0]  cfg_row;
    logic [3:0]  cfg_id;
    logic        cfg_commit;
    logic [47:0] id_bus;
    logic        set_id;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_row_tag;
    logic [4:0]  in_col_tag;
    logic [31:0] in_value;
    logic [3:0]  bus_tag;
    logic [4:0]  bus_tag_id;
    logic [31:0] bus_value;
    logic        bus_enable;
    logic        bus_ready;
    logic        busy;
    logic        stall_clr;
    logic [15:0] stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    gon_y_bus_driver #(
        .NUM_ROWS(12), .ROW_LEN(4), .ID_LEN(5), .VALUE_LEN(32), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_row(cfg_row), .cfg_id(cfg_id), .cfg_commit(cfg_commit),
        .id_bus(id_bus), .set_id(set_id),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_row_tag(in_row_tag), .in_col_tag(in_col_tag), .in_value(in_value),
        .bus_tag(bus_tag), .bus_tag_id(bus_tag_id), .bus_value(bus_value),
        .bus_enable(bus_enable), .bus_ready(bus_ready), .busy(busy),
        .stall_clr(stall_clr), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs are then driven and outputs sampled 1ns later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pkt(input logic v, input logic [3:0] r, input logic [4:0] c,
                           input logic [31:0] d);
        in_valid   = v;
        in_row_tag = r;
        in_col_tag = c;
        in_value   = d;
    endtask

    initial begin
        rst = 1'b0; cfg_we = 1'b0; cfg_row = '0; cfg_id = '0; cfg_commit = 1'b0;
        bus_ready = 1'b0; stall_clr = 1'b0;
        set_pkt(1'b0, 4'd0, 5'd0, 32'd0);
        step(); step();

        // reset state
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_enable",   64'(bus_enable), 64'd0);
        chk("rst_set_id",   64'(set_id), 64'd0);
        chk("rst_id_bus",   64'(id_bus), 64'd0);
        chk("rst_stall",    64'(stall_cnt), 64'd0);
        chk("rst_busy",     64'(busy), 64'd0);
        rst = 1'b1;
        step();
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // three back-to-back packets, bus always ready
        bus_ready = 1'b1;
        set_pkt(1'b1, 4'd2, 5'd5, 32'hA0);
        step();
        chk("t1_enable_e0", 64'(bus_enable), 64'd0);
        set_pkt(1'b1, 4'd2, 5'd5, 32'hA1);
        step();
        chk("t1_enable_e1", 64'(bus_enable), 64'd1);
        chk("t1_val0",      64'(bus_value), 64'hA0);
        chk("t1_tag0",      64'(bus_tag), 64'd2);
        chk("t1_tagid0",    64'(bus_tag_id), 64'd5);
        set_pkt(1'b1, 4'd2, 5'd5, 32'hA2);
        step();
        chk("t1_enable_e2", 64'(bus_enable), 64'd1);
        chk("t1_val1",      64'(bus_value), 64'hA1);
        set_pkt(1'b0, 4'd0, 5'd0, 32'd0);
        step();
        chk("t1_enable_e3", 64'(bus_enable), 64'd1);
        chk("t1_val2",      64'(bus_value), 64'hA2);
        step();
        chk("t1_enable_end", 64'(bus_enable), 64'd0);
        chk("t1_val_end",    64'(bus_value), 64'd0);
        chk("t1_tag_end",    64'(bus_tag), 64'd0);
        chk("t1_stall",      64'(stall_cnt), 64'd0);
        chk("t1_busy",       64'(busy), 64'd0);

        // single packet stalled for five edges
        bus_ready = 1'b0;
        set_pkt(1'b1, 4'd3, 5'd7, 32'h55);
        step();
        set_pkt(1'b0, 4'd0, 5'd0, 32'd0);
        step();
        chk("t2_enable", 64'(bus_enable), 64'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t2_hold_val", 64'(bus_value), 64'h55);
            chk("t2_hold_tag", 64'(bus_tag), 64'd3);
            chk("t2_hold_en",  64'(bus_enable), 64'd1);
        end
        chk("t2_stall5", 64'(stall_cnt), 64'd5);
        bus_ready = 1'b1;
        step();
        chk("t2_done_en",  64'(bus_enable), 64'd0);
        chk("t2_stall_kept", 64'(stall_cnt), 64'd5);

        // fill: bus register plus four FIFO entries hold five packets
        bus_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("t3_in_ready", 64'(in_ready), (i < 5) ? 64'd1 : 64'd0);
            set_pkt(1'b1, 4'd1, 5'd2, 32'hB0 + 32'(i));
            step();
        end
        chk("t3_full", 64'(in_ready), 64'd0);
        set_pkt(1'b0, 4'd0, 5'd0, 32'd0);
        bus_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("t3_drain_val", 64'(bus_value), 64'hB0 + 64'(k));
            chk("t3_drain_en",  64'(bus_enable), 64'd1);
            step();
            if (k == 0) chk("t3_ready_back", 64'(in_ready), 64'd1);
        end
        chk("t3_drained", 64'(bus_enable), 64'd0);

        // shadow writes, ignored row, write+commit in the same cycle
        for (int r = 0; r < 11; r++) begin
            cfg_we = 1'b1; cfg_row = 4'(r); cfg_id = 4'(r);
            step();
        end
        cfg_row = 4'd12; cfg_id = 4'hF;
        step();
        chk("t4_id_pre", 64'(id_bus), 64'h0A9876543210);
        cfg_row = 4'd11; cfg_id = 4'hB; cfg_commit = 1'b1;
        step();
        cfg_we = 1'b0; cfg_commit = 1'b0;
        chk("t4_set_id", 64'(set_id), 64'd1);
        chk("t4_id_bus", 64'(id_bus), 64'hBA9876543210);
        chk("t4_en",     64'(bus_enable), 64'd0);
        chk("t4_busy",   64'(busy), 64'd1);
        step();
        chk("t4_set_id_off", 64'(set_id), 64'd0);
        chk("t4_busy_off",   64'(busy), 64'd0);

        // commit requested twice during a stalled issue
        bus_ready = 1'b0;
        set_pkt(1'b1, 4'd4, 5'd9, 32'hC0);
        step();
        set_pkt(1'b1, 4'd4, 5'd9, 32'hC1);
        step();
        set_pkt(1'b0, 4'd0, 5'd0, 32'd0);
        chk("t5_val", 64'(bus_value), 64'hC0);
        cfg_commit = 1'b1;
        step();
        chk("t5_no_set1", 64'(set_id), 64'd0);
        step();
        cfg_commit = 1'b0;
        chk("t5_no_set2", 64'(set_id), 64'd0);
        step();
        chk("t5_no_set3", 64'(set_id), 64'd0);
        chk("t5_still_en", 64'(bus_enable), 64'd1);
        chk("t5_still_val", 64'(bus_value), 64'hC0);
        bus_ready = 1'b1;
        step();
        chk("t5_set", 64'(set_id), 64'd1);
        chk("t5_set_en", 64'(bus_enable), 64'd0);
        chk("t5_set_val", 64'(bus_value), 64'd0);
        step();
        chk("t5_single_pulse", 64'(set_id), 64'd0);
        chk("t5_idle_en", 64'(bus_enable), 64'd0);
        step();
        chk("t5_resume_en",  64'(bus_enable), 64'd1);
        chk("t5_resume_val", 64'(bus_value), 64'hC1);
        chk("t5_resume_set", 64'(set_id), 64'd0);
        step();
        chk("t5_end_en", 64'(bus_enable), 64'd0);

        // saturation, clear, then reset in the middle of a stall
        stall_clr = 1'b1;
        step();
        stall_clr = 1'b0;
        chk("t6_clr0", 64'(stall_cnt), 64'd0);
        bus_ready = 1'b0;
        set_pkt(1'b1, 4'd6, 5'd1, 32'hD0);
        step();
        set_pkt(1'b0, 4'd0, 5'd0, 32'd0);
        step();
        repeat (70000) @(posedge clk);
        #1;
        chk("t6_sat", 64'(stall_cnt), 64'hFFFF);
        stall_clr = 1'b1;
        step();
        stall_clr = 1'b0;
        chk("t6_clr", 64'(stall_cnt), 64'd0);
        step();
        chk("t6_recount", 64'(stall_cnt), 64'd1);
        rst = 1'b0;
        step();
        chk("t6_rst_en",    64'(bus_enable), 64'd0);
        chk("t6_rst_val",   64'(bus_value), 64'd0);
        chk("t6_rst_tag",   64'(bus_tag), 64'd0);
        chk("t6_rst_stall", 64'(stall_cnt), 64'd0);
        chk("t6_rst_id",    64'(id_bus), 64'd0);
        chk("t6_rst_busy",  64'(busy), 64'd0);
        chk("t6_rst_ready", 64'(in_ready), 64'd0);
        rst = 1'b1;
        step();
        chk("t6_post_ready", 64'(in_ready), 64'd1);
        bus_ready = 1'b1;
        step();
        chk("t6_fifo_gone", 64'(bus_enable), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
